// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin arbiter sharing one valid/ready sink port
// among NUM_REQ stream masters. Each grant lasts up to MAX_BURST accepted
// beats or until the owner drops valid. One IDLE cycle separates tenures.
module rr_stream_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          grant_busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_idx;
    logic [CNT_W-1:0]   beat_cnt;

    logic [DATA_W-1:0]  req_words [NUM_REQ];
    logic               owner_valid;
    logic               accept;
    logic               last_beat;
    logic               release_now;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;

    // Split the flattened data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_words[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Circular priority search starting just after the previous owner.
    // Scanning from the farthest position down lets the nearest valid
    // requester overwrite the result, so the closest one wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Sink-side mux and ready steering; outputs are quiet in IDLE and while
    // reset is held, so a beat presented during reset is never accepted.
    always_comb begin
        m_valid   = 1'b0;
        m_data    = '0;
        req_ready = '0;
        if (state == BUSY && !rst) begin
            m_valid              = owner_valid;
            m_data               = req_words[grant_idx];
            req_ready[grant_idx] = m_ready;
        end
    end

    // Tenure end: burst limit reached on an accepted beat, or owner went idle.
    always_comb begin
        owner_valid = req_valid[grant_idx];
        accept      = m_valid & m_ready;
        last_beat   = (beat_cnt == CNT_W'(MAX_BURST - 1));
        release_now = (state == BUSY) & ((accept & last_beat) | ~owner_valid);
    end

    // Grant FSM: IDLE picks the next owner, BUSY counts beats until release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_busy <= 1'b0;
            grant_idx  <= '0;
            last_idx   <= IDX_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx  <= pick_idx;
                        beat_cnt   <= '0;
                        state      <= BUSY;
                        grant_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        last_idx   <= grant_idx;
                        state      <= IDLE;
                        grant_busy <= 1'b0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    grant_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Testbench for rr_stream_arbiter: scenario tasks driving requesters and a
// sink, each comparing the DUT against a cycle-level reference of the
// arbitration rules plus scenario-specific scoreboards.
module tb_rr_stream_arbiter;

    localparam int NR = 4;
    localparam int MB = 8;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    src_valid = '0;
    logic [DW-1:0]    src_data [NR];
    logic [NR*DW-1:0] req_data_flat;
    logic             m_ready = 1'b0;

    logic [NR-1:0]    req_ready;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic [1:0]       grant_idx;
    logic             grant_busy;

    rr_stream_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (src_valid),
        .req_data   (req_data_flat),
        .req_ready  (req_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .grant_idx  (grant_idx),
        .grant_busy (grant_busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_data_flat = '0;
        for (int i = 0; i < NR; i++) req_data_flat[i*DW +: DW] = src_data[i];
    end

    wire [39:0] dut_vec = {m_valid, m_data, req_ready, grant_busy, grant_idx};
    logic [39:0] exp_vec;

    int n_assert = 0;
    int n_fail   = 0;

    // Requester sources: word = base + number of beats already accepted.
    logic [31:0]   src_base [NR];
    int            src_cnt  [NR];
    logic [NR-1:0] acc_pend = '0;
    logic [NR-1:0] acc_seen = '0;

    // Reference: owner (-1 when no tenure), previous owner, beats in tenure.
    int mo_owner = -1;
    int mo_last  = NR - 1;
    int mo_beats = 0;
    int mo_gidx  = 0;

    task automatic model_eval();
        logic          e_mvalid;
        logic [DW-1:0] e_mdata;
        logic [NR-1:0] e_rdy;
        e_mvalid = 1'b0;
        e_mdata  = '0;
        e_rdy    = '0;
        if (!rst && mo_owner >= 0) begin
            e_mvalid        = src_valid[mo_owner];
            e_mdata         = src_data[mo_owner];
            e_rdy[mo_owner] = m_ready;
        end
        exp_vec = {e_mvalid, e_mdata, e_rdy, (mo_owner >= 0), 2'(mo_gidx)};
    endtask

    task automatic model_advance();
        bit found;
        if (rst) begin
            mo_owner = -1; mo_last = NR - 1; mo_gidx = 0; mo_beats = 0;
        end else if (mo_owner < 0) begin
            found = 0;
            for (int k = 1; k <= NR; k++) begin
                if (!found && src_valid[(mo_last + k) % NR]) begin
                    found    = 1;
                    mo_owner = (mo_last + k) % NR;
                    mo_gidx  = mo_owner;
                    mo_beats = 0;
                end
            end
        end else if (!src_valid[mo_owner]) begin
            mo_last = mo_owner; mo_owner = -1;
        end else if (m_ready) begin
            mo_beats++;
            if (mo_beats == MB) begin
                mo_last = mo_owner; mo_owner = -1;
            end
        end
    endtask

    task automatic begin_cycle();
        @(negedge clk);
        acc_seen = acc_pend;
        for (int i = 0; i < NR; i++) if (acc_pend[i]) src_cnt[i]++;
        acc_pend = '0;
    endtask

    task automatic settle();
        for (int i = 0; i < NR; i++) src_data[i] = src_base[i] + 32'(src_cnt[i]);
        #1;
        model_eval();
    endtask

    task automatic end_cycle();
        acc_pend = src_valid & req_ready;
        model_advance();
    endtask

    task automatic setup_sources();
        for (int i = 0; i < NR; i++) begin
            src_base[i] = 32'(i) << 28;
            src_cnt[i]  = 0;
        end
        acc_pend = '0;
    endtask

    task automatic apply_reset();
        begin_cycle();
        rst = 1'b1; src_valid = '0; m_ready = 1'b0;
        settle();
        end_cycle();
    endtask

    task automatic test_reset();
        setup_sources();
        model_advance();
        for (int c = 0; c < 3; c++) begin
            begin_cycle();
            rst = 1'b1; src_valid = 4'b1111; m_ready = 1'b1;
            settle();
            n_assert++;
            if (m_valid !== 1'b0 || req_ready !== '0 || grant_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_quiet: got valid=%b ready=%b busy=%b, expected 0/0000/0",
                         m_valid, req_ready, grant_busy);
            end
            end_cycle();
        end
        for (int c = 0; c < 2; c++) begin
            begin_cycle();
            rst = 1'b0;
            settle();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_release: got %h expected %h", dut_vec, exp_vec);
            end
            if (c == 1) begin
                n_assert++;
                if (m_valid !== 1'b1 || grant_idx !== 2'd0) begin
                    n_fail++;
                    $display("FAIL reset_first_grant: got valid=%b idx=%0d expected 1/0",
                             m_valid, grant_idx);
                end
            end
            end_cycle();
        end
    endtask

    task automatic test_burst_limit();
        int cur_tag, tag, run, gap, runs_done;
        setup_sources();
        apply_reset();
        cur_tag = -1; run = 0; gap = 0; runs_done = 0;
        for (int c = 0; c < 60; c++) begin
            begin_cycle();
            rst = 1'b0; src_valid = 4'b0101; m_ready = 1'b1;
            settle();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL burst_vec: got %h expected %h", dut_vec, exp_vec);
            end
            if (m_valid && m_ready) begin
                tag = int'(m_data[31:28]);
                if (tag != cur_tag) begin
                    n_assert++;
                    if (cur_tag < 0) begin
                        if (tag != 0) begin
                            n_fail++;
                            $display("FAIL burst_first_owner: got %0d expected 0", tag);
                        end
                    end else begin
                        if (run != MB || gap != 1 || tag != (cur_tag == 0 ? 2 : 0)) begin
                            n_fail++;
                            $display("FAIL burst_run: got run=%0d gap=%0d next=%0d expected run=%0d gap=1 next=%0d",
                                     run, gap, tag, MB, (cur_tag == 0 ? 2 : 0));
                        end
                        runs_done++;
                    end
                    cur_tag = tag; run = 1;
                end else begin
                    n_assert++;
                    if (gap != 0) begin
                        n_fail++;
                        $display("FAIL burst_gap_in_run: got gap=%0d expected 0", gap);
                    end
                    run++;
                end
                gap = 0;
            end else begin
                gap++;
            end
            end_cycle();
        end
        n_assert++;
        if (runs_done < 5) begin
            n_fail++;
            $display("FAIL burst_run_count: got %0d expected at least 5", runs_done);
        end
    endtask

    task automatic test_early_drop();
        logic [31:0] rx[$];
        int idle_after, seen_grant, n1;
        setup_sources();
        src_base[1] = 32'h1111_0001;
        src_base[3] = 32'h3333_0000;
        apply_reset();
        idle_after = 0; seen_grant = 0;
        for (int c = 0; c < 12; c++) begin
            begin_cycle();
            rst = 1'b0; m_ready = 1'b1;
            src_valid = {1'b1, 1'b0, (src_cnt[1] < 3), 1'b0};
            settle();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL drop_vec: got %h expected %h", dut_vec, exp_vec);
            end
            if (grant_busy) seen_grant = 1;
            else if (seen_grant && rx.size() < 4) idle_after++;
            if (m_valid && m_ready) rx.push_back(m_data);
            end_cycle();
        end
        n1 = 0;
        foreach (rx[i]) if (rx[i][31:16] == 16'h1111) n1++;
        n_assert++;
        if (rx.size() < 4 || rx[0] !== 32'h1111_0001 || rx[1] !== 32'h1111_0002 ||
            rx[2] !== 32'h1111_0003 || rx[3][31:16] !== 16'h3333 || n1 != 3) begin
            n_fail++;
            $display("FAIL drop_sequence: got %0d words (%0d from req1), expected 3 from req1 then req3",
                     rx.size(), n1);
        end
        n_assert++;
        if (idle_after != 1) begin
            n_fail++;
            $display("FAIL drop_idle_gap: got %0d idle cycles expected 1", idle_after);
        end
    endtask

    task automatic test_backpressure();
        int rx_next [NR];
        int ten, tag;
        setup_sources();
        for (int i = 0; i < NR; i++) rx_next[i] = 0;
        apply_reset();
        ten = 0;
        for (int c = 0; c < 2000; c++) begin
            begin_cycle();
            rst = 1'b0;
            m_ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < NR; i++) begin
                if (acc_seen[i] || !src_valid[i]) src_valid[i] = ($urandom_range(0, 3) != 0);
            end
            settle();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL bp_vec: cycle %0d got %h expected %h", c, dut_vec, exp_vec);
            end
            n_assert++;
            if ($countones(req_ready) > 1) begin
                n_fail++;
                $display("FAIL bp_onehot: got req_ready=%b expected at most one bit", req_ready);
            end
            if (!grant_busy) ten = 0;
            if (m_valid && m_ready) begin
                tag = int'(m_data[31:28]);
                ten++;
                n_assert++;
                if (tag >= NR) begin
                    n_fail++;
                    $display("FAIL bp_tag: got %0d expected below %0d", tag, NR);
                end else begin
                    if (m_data[27:0] !== 28'(rx_next[tag])) begin
                        n_fail++;
                        $display("FAIL bp_order: req %0d got %0d expected %0d",
                                 tag, m_data[27:0], rx_next[tag]);
                    end
                    rx_next[tag]++;
                end
                n_assert++;
                if (ten > MB) begin
                    n_fail++;
                    $display("FAIL bp_tenure_len: got %0d beats expected at most %0d", ten, MB);
                end
            end
            end_cycle();
        end
        begin_cycle();
        src_valid = '0;
        settle();
        end_cycle();
        for (int i = 0; i < NR; i++) begin
            n_assert++;
            if (rx_next[i] != src_cnt[i] || src_cnt[i] == 0) begin
                n_fail++;
                $display("FAIL bp_delivery: req %0d received %0d expected %0d (nonzero)",
                         i, rx_next[i], src_cnt[i]);
            end
        end
    endtask

    task automatic test_fairness_wrap();
        int first;
        setup_sources();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            begin_cycle();
            rst = 1'b0; m_ready = 1'b1;
            src_valid = {(src_cnt[3] < 1), 3'b000};
            settle();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL wrap_setup_vec: got %h expected %h", dut_vec, exp_vec);
            end
            end_cycle();
        end
        first = -1;
        for (int c = 0; c < 5; c++) begin
            begin_cycle();
            src_valid = 4'b1010;
            settle();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL wrap_vec: got %h expected %h", dut_vec, exp_vec);
            end
            if (first < 0 && grant_busy) first = int'(grant_idx);
            end_cycle();
        end
        n_assert++;
        if (first != 1) begin
            n_fail++;
            $display("FAIL wrap_grant: got %0d expected 1", first);
        end
    endtask

    task automatic test_mid_reset();
        bit reached;
        int first;
        setup_sources();
        apply_reset();
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            begin_cycle();
            rst = 1'b0; m_ready = 1'b1;
            src_valid = (src_cnt[1] >= 1) ? 4'b0100 : 4'b0010;
            settle();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL midrst_vec: got %h expected %h", dut_vec, exp_vec);
            end
            end_cycle();
            if (mo_owner == 2 && mo_beats == 3) reached = 1;
        end
        n_assert++;
        if (!reached) begin
            n_fail++;
            $display("FAIL midrst_setup: requester 2 never reached beat 4, expected it to");
        end
        begin_cycle();
        rst = 1'b1;
        settle();
        n_assert++;
        if (m_valid !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL midrst_during: got valid=%b ready=%b expected 0/0000", m_valid, req_ready);
        end
        end_cycle();
        begin_cycle();
        rst = 1'b0; src_valid = 4'b1110;
        settle();
        n_assert++;
        if (req_ready !== '0 || grant_busy !== 1'b0 || src_cnt[2] != 3) begin
            n_fail++;
            $display("FAIL midrst_after: got ready=%b busy=%b beats2=%0d expected 0000/0/3",
                     req_ready, grant_busy, src_cnt[2]);
        end
        end_cycle();
        first = -1;
        for (int c = 0; c < 5; c++) begin
            begin_cycle();
            settle();
            n_assert++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL midrst_regrant_vec: got %h expected %h", dut_vec, exp_vec);
            end
            if (first < 0 && grant_busy) first = int'(grant_idx);
            end_cycle();
        end
        n_assert++;
        if (first != 1) begin
            n_fail++;
            $display("FAIL midrst_regrant: got %0d expected 1", first);
        end
    endtask

    initial begin
        test_reset();
        test_burst_limit();
        test_early_drop();
        test_backpressure();
        test_fairness_wrap();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/rr_stream_arbiter.md
# rr_stream_arbiter

Round-robin arbiter that shares one 32-bit valid/ready receive port, such as the `slave` sink, among `NUM_REQ` independent stream masters. A winner holds the port for at most `MAX_BURST` accepted beats, or until it drops `valid`. The grant then passes to the next requester in circular order. The block sits between the traffic generators and the sink, and it is the only driver of the sink's `data`/`valid` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `MAX_BURST`, 8: maximum beats per grant tenure, 1..256.
- `DATA_W`, 32: beat width.
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: per-requester valid; bit i belongs to requester i.
- `req_data`  in  NUM_REQ*DATA_W: flattened data; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ: per-requester ready; one-hot or zero.
- `m_data`  out  DATA_W: data to the sink.
- `m_valid`  out  1: valid to the sink.
- `m_ready`  in  1: ready from the sink; may toggle arbitrarily, including randomly every cycle.
- `grant_idx`  out  $clog2(NUM_REQ): current or most recent owner.
- `grant_busy`  out  1: high while a tenure is active.

## Operation
- Two-state FSM: IDLE and BUSY. The state register, `grant_idx`, `last_idx` and `beat_cnt` are registered.
- Reset values:
  - state = IDLE, `grant_busy`=0, `grant_idx`=0.
  - `last_idx`=NUM_REQ-1, so requester 0 has first priority.
  - `beat_cnt`=0.
  - `m_valid`=0, `req_ready`=0. `m_data` is don't-care; it is driven as 0 in IDLE.
- IDLE:
  - If any `req_valid` bit is set, pick the first set bit scanning `last_idx`+1, +2, … modulo NUM_REQ.
  - Load that index into `grant_idx`, clear `beat_cnt`, go to BUSY.
  - No transfer occurs in IDLE: `m_valid`=0 and `req_ready`=0.
- BUSY, outputs are combinational from `grant_idx`:
  - `m_valid` = `req_valid[grant_idx]`; `m_data` = slice `grant_idx` of `req_data`.
  - `req_ready[grant_idx]` = `m_ready`; all other `req_ready` bits are 0.
  - A beat is accepted when `m_valid & m_ready`; each accepted beat increments `beat_cnt`.
- Release conditions, evaluated each BUSY cycle:
  - (a) a beat is accepted and `beat_cnt`==MAX_BURST-1, or
  - (b) `req_valid[grant_idx]`==0.
- On release: `last_idx` ← `grant_idx`, go to IDLE, `grant_busy` falls next cycle. `grant_idx` holds its value.
- Fairness: a requester that keeps `valid` high cannot win twice in a row while any other requester is valid.
- Counter width is $clog2(MAX_BURST+1). `beat_cnt` never exceeds MAX_BURST-1 in BUSY, so it never wraps.
- Simultaneous events:
  - Acceptance of the final beat together with the owner dropping `valid` in the same cycle cannot occur, since acceptance requires `valid`; condition (a) applies.
  - New requests arriving during BUSY are only sampled in IDLE.
- AXI-stream-like rule assumed from requesters: once `valid` is raised, data is held until accepted. The arbiter does not check this. Dropping `valid` early simply ends the tenure.
- Reset asserted mid-tenure: on the next edge all state returns to reset values. The in-flight beat is not accepted, and `req_ready` is 0 in the following cycle.

## Timing
- Arbitration latency: one cycle from `req_valid` rising (seen in IDLE) to the first cycle `m_valid` can be high.
- Turnaround: each tenure costs exactly one dead IDLE cycle, giving peak throughput MAX_BURST/(MAX_BURST+1) beats per cycle under a continuous `m_ready`.
- Combinational paths in BUSY: `req_valid` → `m_valid`, `req_data` → `m_data`, and `m_ready` → `req_ready`.
  - There is no path from `m_ready` to `m_valid`.
  - The mux depth is log2(NUM_REQ).
- `grant_busy` equals (state==BUSY) and is registered.

## Test plan
- Reset behaviour:
  - Stimulus: hold `rst`=1 for 3 cycles with all `req_valid`=4'b1111 and `m_ready`=1.
  - Required: `m_valid`=0, `req_ready`=0, `grant_busy`=0 throughout. First grant after release goes to requester 0, with `m_valid` high 1 cycle after `rst` drops.
- Burst limit:
  - Stimulus: requesters 0 and 2 continuously valid, `m_ready`=1, MAX_BURST=8.
  - Required: beats from requesters 0, 2, 0, 2… alternate in runs of exactly 8. One idle cycle separates runs: 8 beats per 9 cycles.
- Early drop:
  - Stimulus: requester 1 sends 3 beats (0x11110001..0x11110003) and then drops `valid`; requester 3 is valid.
  - Required: the tenure ends after 3 beats. The next tenure goes to requester 3 after one IDLE cycle.
- Backpressure:
  - Stimulus: `m_ready` driven by $urandom_range(0,1) for 2000 cycles; all 4 requesters send incrementing counters tagged with their index.
  - Required:
    - Every sent word arrives exactly once, in per-requester order.
    - `req_ready` is never multi-hot.
    - No tenure exceeds 8 accepted beats.
- Fairness wrap-around:
  - Stimulus: `last_idx`=3 state reached, then only requesters 3 and 1 valid.
  - Required: requester 1 is granted before 3.
- Mid-tenure reset:
  - Stimulus: assert `rst` for 1 cycle during beat 4 of a requester 2 tenure.
  - Required: that beat is not accepted. The next grant starts from requester 0's priority position.
